// File: rtl/uart_ctrl_regbank.sv
// Dual-writer UART control register bank with a self-clearing START command handshake.
// Latency: writes land on the clock edge; read data and status pulses are registered (1 cycle).
// Backpressure: none on writes; the START command holds cmd_req until cmd_ack is seen.
//
// Ports:
//   clk_i, rst_n_i          clock and asynchronous active-low reset
//   usr_we_i/addr/be/wdata  user bus write (byte enables); usr_rdata_o is registered read of usr_addr_i
//   hw_we_i/addr/wmask/wdata UART-side write with per-bit mask (user wins on overlapping bits)
//   regs_o                  all registers flattened, reg k at [k*DATA_W +: DATA_W]
//   cmd_req_o, cmd_ack_i    command handshake driven by START (reg 0, bit START_BIT)
//   done_o                  one-cycle pulse after the ack is accepted
//   wr_conflict_o           one-cycle pulse after an edge where both writers hit the same bits
module uart_ctrl_regbank #(
   parameter int                DATA_W    = 32,
   parameter int                NUM_REGS  = 4,
   parameter int                ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter logic [DATA_W-1:0] RST_VAL   = '0,
   parameter int                START_BIT = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       usr_we_i,
   input  logic [ADDR_W-1:0]          usr_addr_i,
   input  logic [DATA_W/8-1:0]        usr_be_i,
   input  logic [DATA_W-1:0]          usr_wdata_i,
   output logic [DATA_W-1:0]          usr_rdata_o,
   input  logic                       hw_we_i,
   input  logic [ADDR_W-1:0]          hw_addr_i,
   input  logic [DATA_W-1:0]          hw_wmask_i,
   input  logic [DATA_W-1:0]          hw_wdata_i,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                       cmd_req_o,
   input  logic                       cmd_ack_i,
   output logic                       done_o,
   output logic                       wr_conflict_o
);

   localparam int NUM_BYTES  = DATA_W / 8;
   localparam int START_BYTE = START_BIT / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   regs      [NUM_REGS];
   logic [DATA_W-1:0]   regs_next [NUM_REGS];
   logic [NUM_REGS-1:0] usr_sel;
   logic [NUM_REGS-1:0] hw_sel;
   logic [DATA_W-1:0]   be_mask;
   logic [DATA_W-1:0]   rd_mux;
   logic                conflict_next;
   logic                start_usr_wr;
   logic                start_hw_val;
   logic                start_next;

   // Address decode. Out-of-range addresses match no register, so such
   // writes fall away and reads return zero without a separate range check.
   always_comb begin
      usr_sel = '0;
      hw_sel  = '0;
      rd_mux  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         usr_sel[k] = usr_we_i && (usr_addr_i == ADDR_W'(k));
         hw_sel[k]  = hw_we_i  && (hw_addr_i  == ADDR_W'(k));
         if (usr_addr_i == ADDR_W'(k)) begin
            rd_mux = regs[k];
         end
      end
   end

   always_comb begin
      be_mask = '0;
      for (int j = 0; j < NUM_BYTES; j++) begin
         be_mask[j*8 +: 8] = {8{usr_be_i[j]}};
      end
   end

   // Conflict needs a shared register and at least one bit claimed by both writers.
   assign conflict_next = (|(usr_sel & hw_sel)) && (|(be_mask & hw_wmask_i));

   // START bit next value. The hw side can only ever clear it, and only
   // while idle; during REQ/DONE the bit belongs to the handshake.
   always_comb begin
      start_usr_wr = usr_sel[0] && usr_be_i[START_BYTE];
      start_hw_val = (hw_sel[0] && hw_wmask_i[START_BIT]) ? hw_wdata_i[START_BIT]
                                                           : regs[0][START_BIT];
      start_next   = regs[0][START_BIT];
      case (state)
         ST_IDLE: begin
            if (start_usr_wr) begin
               start_next = usr_wdata_i[START_BIT];
            end else begin
               start_next = regs[0][START_BIT] & start_hw_val;
            end
         end
         ST_REQ: begin
            if (cmd_ack_i) begin
               start_next = 1'b0;
            end
         end
         default: start_next = regs[0][START_BIT];
      endcase
   end

   // Per-bit merge: hw bits first, user bytes on top so the user wins overlaps.
   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_next[k] = regs[k];
         if (hw_sel[k]) begin
            regs_next[k] = (regs_next[k] & ~hw_wmask_i) | (hw_wdata_i & hw_wmask_i);
         end
         if (usr_sel[k]) begin
            regs_next[k] = (regs_next[k] & ~be_mask) | (usr_wdata_i & be_mask);
         end
      end
      regs_next[0][START_BIT] = start_next;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= RST_VAL;
         end
         usr_rdata_o   <= '0;
         wr_conflict_o <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= regs_next[k];
         end
         // Read samples the pre-write contents.
         usr_rdata_o   <= rd_mux;
         wr_conflict_o <= conflict_next;
      end
   end

   // Command handshake. cmd_req_o and done_o are registered here so the
   // engine never sees a combinational path from the bus or from the ack.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_IDLE;
         cmd_req_o <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_o <= 1'b0;
               if (start_next) begin
                  state     <= ST_REQ;
                  cmd_req_o <= 1'b1;
               end
            end
            ST_REQ: begin
               if (cmd_ack_i) begin
                  state     <= ST_DONE;
                  cmd_req_o <= 1'b0;
                  done_o    <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               cmd_req_o <= 1'b0;
               done_o    <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule

// File: tb/tb_uart_ctrl_regbank.sv
module tb_uart_ctrl_regbank;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;

   // Four-register instance
   logic          usr_we;
   logic [1:0]    usr_addr;
   logic [3:0]    usr_be;
   logic [31:0]   usr_wdata;
   logic [31:0]   usr_rdata;
   logic          hw_we;
   logic [1:0]    hw_addr;
   logic [31:0]   hw_wmask;
   logic [31:0]   hw_wdata;
   logic [127:0]  regs;
   logic          cmd_req;
   logic          cmd_ack;
   logic          done;
   logic          wr_conflict;

   // Three-register instance for the out-of-range address case
   logic          u3_we;
   logic [1:0]    u3_addr;
   logic [3:0]    u3_be;
   logic [31:0]   u3_wdata;
   logic [31:0]   u3_rdata;
   logic          h3_we;
   logic [1:0]    h3_addr;
   logic [31:0]   h3_wmask;
   logic [31:0]   h3_wdata;
   logic [95:0]   regs3;
   logic          req3;
   logic          ack3;
   logic          done3;
   logic          conf3;

   int errors = 0;
   int checks = 0;

   uart_ctrl_regbank #(.DATA_W(32), .NUM_REGS(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .usr_we_i(usr_we), .usr_addr_i(usr_addr), .usr_be_i(usr_be),
      .usr_wdata_i(usr_wdata), .usr_rdata_o(usr_rdata),
      .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wmask_i(hw_wmask), .hw_wdata_i(hw_wdata),
      .regs_o(regs), .cmd_req_o(cmd_req), .cmd_ack_i(cmd_ack),
      .done_o(done), .wr_conflict_o(wr_conflict)
   );

   uart_ctrl_regbank #(.DATA_W(32), .NUM_REGS(3)) dut3 (
      .clk_i(clk), .rst_n_i(rst_n),
      .usr_we_i(u3_we), .usr_addr_i(u3_addr), .usr_be_i(u3_be),
      .usr_wdata_i(u3_wdata), .usr_rdata_o(u3_rdata),
      .hw_we_i(h3_we), .hw_addr_i(h3_addr), .hw_wmask_i(h3_wmask), .hw_wdata_i(h3_wdata),
      .regs_o(regs3), .cmd_req_o(req3), .cmd_ack_i(ack3),
      .done_o(done3), .wr_conflict_o(conf3)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input int k);
      return regs[k*32 +: 32];
   endfunction

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic usr_wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      usr_we = 1'b1; usr_addr = a; usr_be = be; usr_wdata = d;
   endtask

   task automatic hw_wr(input logic [1:0] a, input logic [31:0] m, input logic [31:0] d);
      hw_we = 1'b1; hw_addr = a; hw_wmask = m; hw_wdata = d;
   endtask

   task automatic quiet();
      usr_we = 1'b0; hw_we = 1'b0; usr_be = 4'h0; hw_wmask = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      usr_we = 0; usr_addr = 0; usr_be = 0; usr_wdata = 0;
      hw_we = 0; hw_addr = 0; hw_wmask = 0; hw_wdata = 0; cmd_ack = 0;
      u3_we = 0; u3_addr = 0; u3_be = 0; u3_wdata = 0;
      h3_we = 0; h3_addr = 0; h3_wmask = 0; h3_wdata = 0; ack3 = 0;

      // Reset state
      #20;
      check("rst_reg0", reg_of(0), 32'h0);
      check("rst_reg3", reg_of(3), 32'h0);
      check("rst_rdata", usr_rdata, 32'h0);
      check("rst_req", {31'b0, cmd_req}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_conflict", {31'b0, wr_conflict}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Byte enables
      usr_wr(2'd1, 4'b0101, 32'hAABBCCDD);
      tick();
      check("be_reg1", reg_of(1), 32'h00BB00DD);
      check("be_no_conflict", {31'b0, wr_conflict}, 32'h0);

      // Merge without overlap
      hw_wr(2'd2, 32'hFFFF0000, 32'h12345678);
      usr_wr(2'd2, 4'b0001, 32'h000000EE);
      tick();
      check("merge_reg2", reg_of(2), 32'h123400EE);
      check("merge_conflict0", {31'b0, wr_conflict}, 32'h0);
      // Clear reg2, then merge with overlap on byte 3
      quiet();
      usr_wr(2'd2, 4'b1111, 32'h0);
      tick();
      check("clear_reg2", reg_of(2), 32'h0);
      quiet();
      hw_wr(2'd2, 32'hFFFF0000, 32'h12345678);
      usr_wr(2'd2, 4'b1000, 32'h99000000);
      tick();
      check("overlap_reg2", reg_of(2), 32'h99340000);
      check("overlap_conflict1", {31'b0, wr_conflict}, 32'h1);
      quiet();
      tick();
      check("conflict_pulse_end", {31'b0, wr_conflict}, 32'h0);
      // Same register, disjoint bits: no conflict
      hw_wr(2'd1, 32'h0000FF00, 32'h00001100);
      usr_wr(2'd1, 4'b0001, 32'h00000022);
      tick();
      check("disjoint_reg1", reg_of(1), 32'h00BB1122);
      check("disjoint_conflict0", {31'b0, wr_conflict}, 32'h0);

      // Read latency and pre-write value
      quiet();
      usr_wr(2'd3, 4'b1111, 32'hCAFEF00D);
      tick();
      check("rd_prewrite0", usr_rdata, 32'h0);
      quiet();
      usr_addr = 2'd3;
      tick();
      check("rd_reg3", usr_rdata, 32'hCAFEF00D);
      usr_wr(2'd3, 4'b1111, 32'h11112222);
      tick();
      check("rd_prewrite_old", usr_rdata, 32'hCAFEF00D);
      quiet();
      tick();
      check("rd_reg3_new", usr_rdata, 32'h11112222);

      // hw cannot set START; ack outside REQ ignored
      hw_wr(2'd0, 32'h00000001, 32'h00000001);
      cmd_ack = 1'b1;
      tick();
      check("hw_no_set_start", reg_of(0), 32'h0);
      check("hw_no_req", {31'b0, cmd_req}, 32'h0);
      check("idle_ack_no_done", {31'b0, done}, 32'h0);
      quiet();
      cmd_ack = 1'b0;

      // Handshake
      usr_wr(2'd0, 4'b0001, 32'h00000001);
      tick();
      check("hs_req_set", {31'b0, cmd_req}, 32'h1);
      check("hs_start_set", reg_of(0), 32'h1);
      quiet();
      for (int i = 0; i < 5; i++) tick();
      check("hs_req_held", {31'b0, cmd_req}, 32'h1);
      check("hs_no_early_done", {31'b0, done}, 32'h0);
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      check("hs_req_drop", {31'b0, cmd_req}, 32'h0);
      check("hs_done", {31'b0, done}, 32'h1);
      check("hs_start_clr", reg_of(0), 32'h0);
      tick();
      check("hs_done_pulse", {31'b0, done}, 32'h0);

      // START writes ignored in REQ, other bits still land
      usr_wr(2'd0, 4'b0001, 32'h00000001);
      tick();
      check("req2_set", {31'b0, cmd_req}, 32'h1);
      quiet();
      usr_wr(2'd0, 4'b1111, 32'h0000AB00);
      tick();
      check("req_usr_clr_ignored", reg_of(0), 32'h0000AB01);
      check("req_still1", {31'b0, cmd_req}, 32'h1);
      quiet();
      hw_wr(2'd0, 32'h000000F1, 32'h000000F0);
      tick();
      check("req_hw_ignored", reg_of(0), 32'h0000ABF1);
      check("req_still2", {31'b0, cmd_req}, 32'h1);
      quiet();
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      check("req2_done", {31'b0, done}, 32'h1);
      check("req2_start_clr", reg_of(0), 32'h0000ABF0);
      tick();

      // Async reset in the middle of REQ
      usr_wr(2'd0, 4'b0001, 32'h00000001);
      usr_addr = 2'd0;
      tick();
      quiet();
      check("req3_set", {31'b0, cmd_req}, 32'h1);
      #20;
      rst_n = 1'b0;
      #2;
      check("arst_req", {31'b0, cmd_req}, 32'h0);
      check("arst_reg0", reg_of(0), 32'h0);
      check("arst_reg1", reg_of(1), 32'h0);
      check("arst_reg3", reg_of(3), 32'h0);
      check("arst_rdata", usr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_stays_idle", {31'b0, cmd_req}, 32'h0);

      // Three-register instance: address 3 is out of range
      u3_we = 1'b1; u3_addr = 2'd2; u3_be = 4'hF; u3_wdata = 32'h5A5A5A5A;
      tick();
      u3_addr = 2'd3; u3_wdata = 32'hCAFEF00D;
      tick();
      check("oor_reg0", regs3[31:0], 32'h0);
      check("oor_reg1", regs3[63:32], 32'h0);
      check("oor_reg2_kept", regs3[95:64], 32'h5A5A5A5A);
      u3_we = 1'b0; u3_addr = 2'd3;
      tick();
      check("oor_read0", u3_rdata, 32'h0);
      u3_addr = 2'd2;
      tick();
      check("inrange_read", u3_rdata, 32'h5A5A5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
